// File: rtl/date_pkg.sv
// Shared definitions for the calendar date stage.
// Holds the default select codes, month-length constants, the edit-field
// encoding and a helper that returns the length of a month.
package date_pkg;

    localparam int unsigned SEL_DAY_CODE   = 3;
    localparam int unsigned SEL_MONTH_CODE = 4;
    localparam int unsigned SEL_YEAR_CODE  = 5;

    localparam logic [4:0] DIM_28 = 5'd28;
    localparam logic [4:0] DIM_29 = 5'd29;
    localparam logic [4:0] DIM_30 = 5'd30;
    localparam logic [4:0] DIM_31 = 5'd31;

    typedef enum logic [1:0] {
        FIELD_NONE,
        FIELD_DAY,
        FIELD_MONTH,
        FIELD_YEAR
    } field_e;

    function automatic logic [4:0] month_length(input logic [3:0] month,
                                                input logic       leap);
        logic [4:0] len;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: len = DIM_30;
            4'd2:                    len = leap ? DIM_29 : DIM_28;
            default:                 len = DIM_31;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/leap_year.sv
// Gregorian leap-year test: divisible by 4 and (not by 100 or by 400).
// Year 0 is divisible by 400 and therefore counts as a leap year.
// Ports:
//   year  in   YEAR_W  binary year
//   leap  out  1       year is a leap year
module leap_year #(
    parameter int unsigned YEAR_W = 14
) (
    input  logic [YEAR_W-1:0] year,
    output logic              leap
);

    logic [31:0] y;

    assign y    = 32'(year);
    assign leap = ((y % 32'd4) == 32'd0) &&
                  (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));

endmodule

// File: rtl/date_counter.sv
// Calendar date stage: day/month/year registers advanced by the day-rollover
// carry from the hour stage, with edge-detected up/down editing of each field.
// Ports:
//   clk_1Hz        in   1       system tick, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   en_1           in   1       count enable
//   carry_in       in   1       day rollover pulse
//   up, down       in   1       debounced button levels
//   select_item    in   SEL_W   field under edit
//   day_bin        out  5       day 1..31
//   month_bin      out  4       month 1..12
//   year_bin       out  YEAR_W  year
//   days_in_month  out  5       length of the current month
//   leap           out  1       current year is a leap year
//   edit_active    out  1       select_item addresses a field
//   carry_out      out  1       one-cycle pulse on YEAR_MAX -> YEAR_MIN wrap
module date_counter
    import date_pkg::*;
#(
    parameter int unsigned YEAR_W      = 14,
    parameter int unsigned YEAR_MIN    = 0,
    parameter int unsigned YEAR_MAX    = 9999,
    parameter int unsigned RESET_DAY   = 1,
    parameter int unsigned RESET_MONTH = 1,
    parameter int unsigned RESET_YEAR  = 2000,
    parameter int unsigned SEL_W       = 3,
    parameter logic [SEL_W-1:0] SEL_DAY   = SEL_W'(SEL_DAY_CODE),
    parameter logic [SEL_W-1:0] SEL_MONTH = SEL_W'(SEL_MONTH_CODE),
    parameter logic [SEL_W-1:0] SEL_YEAR  = SEL_W'(SEL_YEAR_CODE)
) (
    input  logic              clk_1Hz,
    input  logic              rst_n,
    input  logic              en_1,
    input  logic              carry_in,
    input  logic              up,
    input  logic              down,
    input  logic [SEL_W-1:0]  select_item,
    output logic [4:0]        day_bin,
    output logic [3:0]        month_bin,
    output logic [YEAR_W-1:0] year_bin,
    output logic [4:0]        days_in_month,
    output logic              leap,
    output logic              edit_active,
    output logic              carry_out
);

    localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_ONE = YEAR_W'(1);

    logic [4:0]        day_q, day_d, day_raw;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              carry_out_q, carry_out_d;
    logic              up_q, down_q;
    logic              up_p, down_p, inc, dec;
    logic              leap_d;
    logic [4:0]        dim_d;
    field_e            field;

    leap_year #(.YEAR_W(YEAR_W)) u_leap_cur (.year(year_q), .leap(leap));
    leap_year #(.YEAR_W(YEAR_W)) u_leap_nxt (.year(year_d), .leap(leap_d));

    assign days_in_month = month_length(month_q, leap);

    always_comb begin
        field = FIELD_NONE;
        if (select_item == SEL_DAY)
            field = FIELD_DAY;
        else if (select_item == SEL_MONTH)
            field = FIELD_MONTH;
        else if (select_item == SEL_YEAR)
            field = FIELD_YEAR;
    end

    assign edit_active = (field != FIELD_NONE);

    // Simultaneous rising edges on both buttons cancel each other.
    assign up_p   = up & ~up_q;
    assign down_p = down & ~down_q;
    assign inc    = up_p & ~down_p;
    assign dec    = down_p & ~up_p;

    always_comb begin
        day_raw     = day_q;
        month_d     = month_q;
        year_d      = year_q;
        carry_out_d = 1'b0;
        case (field)
            FIELD_DAY: begin
                if (inc)
                    day_raw = (day_q >= days_in_month) ? 5'd1 : day_q + 5'd1;
                else if (dec)
                    day_raw = (day_q <= 5'd1) ? days_in_month : day_q - 5'd1;
            end
            FIELD_MONTH: begin
                if (inc)
                    month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                else if (dec)
                    month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
            end
            FIELD_YEAR: begin
                if (inc)
                    year_d = (year_q >= Y_MAX) ? Y_MIN : year_q + Y_ONE;
                else if (dec)
                    year_d = (year_q <= Y_MIN) ? Y_MAX : year_q - Y_ONE;
            end
            FIELD_NONE: begin
                if (en_1 && carry_in) begin
                    if (day_q >= days_in_month) begin
                        day_raw = 5'd1;
                        if (month_q >= 4'd12) begin
                            month_d = 4'd1;
                            if (year_q >= Y_MAX) begin
                                year_d      = Y_MIN;
                                carry_out_d = 1'b1;
                            end else begin
                                year_d = year_q + Y_ONE;
                            end
                        end else begin
                            month_d = month_q + 4'd1;
                        end
                    end else begin
                        day_raw = day_q + 5'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Clamp against the length of the month the date is moving into, using
    // the leap flag of the next year so year edits turn Feb 29 into Feb 28.
    assign dim_d = month_length(month_d, leap_d);
    assign day_d = (day_raw > dim_d) ? dim_d : day_raw;

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            day_q       <= 5'(RESET_DAY);
            month_q     <= 4'(RESET_MONTH);
            year_q      <= YEAR_W'(RESET_YEAR);
            carry_out_q <= 1'b0;
            up_q        <= 1'b1;
            down_q      <= 1'b1;
        end else begin
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            carry_out_q <= carry_out_d;
            up_q        <= up;
            down_q      <= down;
        end
    end

    assign day_bin   = day_q;
    assign month_bin = month_q;
    assign year_bin  = year_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_date_counter.sv
// Self-checking bench for date_counter: a table of one-cycle vectors for
// editing and counting, plus hand-written sequences for leap years, the
// millennium wrap, clamping and reset behaviour.
module tb_date_counter;

    logic        clk_1Hz;
    logic        rst_n;
    logic        en_1;
    logic        carry_in;
    logic        up;
    logic        down;
    logic [2:0]  select_item;
    logic [4:0]  day_bin;
    logic [3:0]  month_bin;
    logic [13:0] year_bin;
    logic [4:0]  days_in_month;
    logic        leap;
    logic        edit_active;
    logic        carry_out;

    int checks = 0;
    int errors = 0;

    date_counter dut (
        .clk_1Hz      (clk_1Hz),
        .rst_n        (rst_n),
        .en_1         (en_1),
        .carry_in     (carry_in),
        .up           (up),
        .down         (down),
        .select_item  (select_item),
        .day_bin      (day_bin),
        .month_bin    (month_bin),
        .year_bin     (year_bin),
        .days_in_month(days_in_month),
        .leap         (leap),
        .edit_active  (edit_active),
        .carry_out    (carry_out)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic       car;
        logic       u;
        logic       dn;
        int         d;
        int         m;
        int         y;
        logic       co;
        logic       lp;
        int         dim;
        logic       ea;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_date(input string name, input int d, input int m, input int y);
        chk({name, ".day"},   int'(day_bin),   d);
        chk({name, ".month"}, int'(month_bin), m);
        chk({name, ".year"},  int'(year_bin),  y);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en_1 = 1'b0; carry_in = 1'b0;
        up = 1'b0; down = 1'b0; select_item = 3'd0;
        @(negedge clk_1Hz);
        @(negedge clk_1Hz);
        rst_n = 1'b1;
        @(negedge clk_1Hz);
    endtask

    task automatic press(input logic [2:0] s, input bit go_up);
        select_item = s;
        if (go_up) up = 1'b1; else down = 1'b1;
        @(negedge clk_1Hz);
        up = 1'b0; down = 1'b0;
        @(negedge clk_1Hz);
    endtask

    task automatic carry_step();
        select_item = 3'd0; en_1 = 1'b1; carry_in = 1'b1;
        @(negedge clk_1Hz);
        carry_in = 1'b0;
    endtask

    // Starts from the reset date 2000-01-01 and walks there with edits.
    task automatic set_date(input int td, input int tm, input int ty);
        int fwd;
        do_reset();
        fwd = (ty - 2000 + 10000) % 10000;
        if (fwd <= 5000) repeat (fwd) press(3'd5, 1'b1);
        else repeat (10000 - fwd) press(3'd5, 1'b0);
        repeat (tm - 1) press(3'd4, 1'b1);
        repeat (td - 1) press(3'd3, 1'b1);
        select_item = 3'd0;
        chk_date("set_date", td, tm, ty);
        chk("set_date.carry_out", int'(carry_out), 0);
    endtask

    initial begin
        //            sel  en  car  up  dn   d  m  y     co  lp  dim ea
        tbl[0]  = '{3'd3, 0, 0, 1, 0,  2, 1, 2000, 0, 1, 31, 1};
        tbl[1]  = '{3'd3, 0, 0, 1, 0,  2, 1, 2000, 0, 1, 31, 1};
        tbl[2]  = '{3'd3, 0, 0, 1, 0,  2, 1, 2000, 0, 1, 31, 1};
        tbl[3]  = '{3'd3, 0, 0, 1, 0,  2, 1, 2000, 0, 1, 31, 1};
        tbl[4]  = '{3'd3, 0, 0, 1, 0,  2, 1, 2000, 0, 1, 31, 1};
        tbl[5]  = '{3'd3, 0, 0, 0, 0,  2, 1, 2000, 0, 1, 31, 1};
        tbl[6]  = '{3'd3, 0, 0, 1, 1,  2, 1, 2000, 0, 1, 31, 1};
        tbl[7]  = '{3'd3, 0, 0, 0, 0,  2, 1, 2000, 0, 1, 31, 1};
        tbl[8]  = '{3'd3, 0, 0, 0, 1,  1, 1, 2000, 0, 1, 31, 1};
        tbl[9]  = '{3'd3, 0, 0, 0, 0,  1, 1, 2000, 0, 1, 31, 1};
        tbl[10] = '{3'd3, 0, 0, 0, 1, 31, 1, 2000, 0, 1, 31, 1};
        tbl[11] = '{3'd3, 0, 0, 0, 0, 31, 1, 2000, 0, 1, 31, 1};
        tbl[12] = '{3'd4, 0, 0, 1, 0, 29, 2, 2000, 0, 1, 29, 1};
        tbl[13] = '{3'd4, 0, 0, 0, 0, 29, 2, 2000, 0, 1, 29, 1};
        tbl[14] = '{3'd5, 0, 0, 1, 0, 28, 2, 2001, 0, 0, 28, 1};
        tbl[15] = '{3'd5, 0, 0, 0, 0, 28, 2, 2001, 0, 0, 28, 1};
        tbl[16] = '{3'd5, 0, 0, 0, 1, 28, 2, 2000, 0, 1, 29, 1};
        tbl[17] = '{3'd5, 0, 0, 0, 0, 28, 2, 2000, 0, 1, 29, 1};
        tbl[18] = '{3'd5, 1, 1, 0, 0, 28, 2, 2000, 0, 1, 29, 1};
        tbl[19] = '{3'd0, 1, 0, 1, 0, 28, 2, 2000, 0, 1, 29, 0};
        tbl[20] = '{3'd0, 1, 1, 0, 0, 29, 2, 2000, 0, 1, 29, 0};
        tbl[21] = '{3'd0, 1, 1, 0, 0,  1, 3, 2000, 0, 1, 31, 0};
        tbl[22] = '{3'd0, 0, 1, 0, 0,  1, 3, 2000, 0, 1, 31, 0};
        tbl[23] = '{3'd7, 0, 0, 1, 0,  1, 3, 2000, 0, 1, 31, 0};
        tbl[24] = '{3'd3, 0, 0, 1, 0,  1, 3, 2000, 0, 1, 31, 1};
        tbl[25] = '{3'd3, 0, 0, 0, 0,  1, 3, 2000, 0, 1, 31, 1};

        rst_n = 1'b0; en_1 = 1'b0; carry_in = 1'b0;
        up = 1'b0; down = 1'b0; select_item = 3'd0;
        @(negedge clk_1Hz);

        // Reset state and a month of day carries.
        do_reset();
        chk_date("reset", 1, 1, 2000);
        chk("reset.carry_out", int'(carry_out), 0);
        chk("reset.leap", int'(leap), 1);
        chk("reset.dim", int'(days_in_month), 31);
        en_1 = 1'b1; carry_in = 1'b1;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk_1Hz);
            chk("count.carry_out", int'(carry_out), 0);
        end
        carry_in = 1'b0;
        chk_date("count31", 1, 2, 2000);
        chk("count31.dim", int'(days_in_month), 29);

        // Table of single-cycle vectors from the reset date.
        do_reset();
        for (int i = 0; i < 26; i++) begin
            select_item = tbl[i].sel;
            en_1        = tbl[i].en;
            carry_in    = tbl[i].car;
            up          = tbl[i].u;
            down        = tbl[i].dn;
            @(negedge clk_1Hz);
            chk($sformatf("vec%0d.day", i),   int'(day_bin),       tbl[i].d);
            chk($sformatf("vec%0d.month", i), int'(month_bin),     tbl[i].m);
            chk($sformatf("vec%0d.year", i),  int'(year_bin),      tbl[i].y);
            chk($sformatf("vec%0d.co", i),    int'(carry_out),     int'(tbl[i].co));
            chk($sformatf("vec%0d.leap", i),  int'(leap),          int'(tbl[i].lp));
            chk($sformatf("vec%0d.dim", i),   int'(days_in_month), tbl[i].dim);
            chk($sformatf("vec%0d.edit", i),  int'(edit_active),   int'(tbl[i].ea));
        end
        up = 1'b0; down = 1'b0; select_item = 3'd0; carry_in = 1'b0;

        // Century year that is not a leap year.
        set_date(28, 2, 1900);
        chk("y1900.leap", int'(leap), 0);
        chk("y1900.dim", int'(days_in_month), 28);
        carry_step();
        chk_date("y1900.next", 1, 3, 1900);

        set_date(1, 1, 2024);
        chk("y2024.leap", int'(leap), 1);
        set_date(1, 1, 2100);
        chk("y2100.leap", int'(leap), 0);

        // Millennium wrap with a single-cycle carry_out.
        set_date(31, 12, 9999);
        carry_step();
        chk_date("wrap", 1, 1, 0);
        chk("wrap.carry_out", int'(carry_out), 1);
        chk("wrap.leap", int'(leap), 1);
        @(negedge clk_1Hz);
        chk("wrap.carry_out_after", int'(carry_out), 0);
        chk_date("wrap.after", 1, 1, 0);

        // Day clamping on month and year edits.
        set_date(31, 1, 2023);
        press(3'd4, 1'b1);
        chk_date("clamp.month", 28, 2, 2023);
        set_date(29, 2, 2024);
        press(3'd5, 1'b1);
        chk_date("clamp.year", 28, 2, 2025);

        // Asynchronous reset mid-edit, button held through release.
        do_reset();
        select_item = 3'd3; up = 1'b1;
        @(negedge clk_1Hz);
        chk("midrst.before", int'(day_bin), 2);
        en_1 = 1'b1; carry_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_date("midrst.async", 1, 1, 2000);
        chk("midrst.carry_out", int'(carry_out), 0);
        carry_in = 1'b0; en_1 = 1'b0;
        @(negedge clk_1Hz);
        rst_n = 1'b1;
        @(negedge clk_1Hz);
        @(negedge clk_1Hz);
        chk("midrst.held", int'(day_bin), 1);
        up = 1'b0;
        @(negedge clk_1Hz);
        press(3'd3, 1'b1);
        chk("midrst.repress", int'(day_bin), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
